// File: rtl/picomips_pipe_cpu.sv
// rtl/picomips_pipe_cpu.sv - two-stage (fetch/execute) parametrised picoMIPS core
//
// Purpose: picoMIPS CPU core with an external combinational program ROM, a
// valid/ready input port, a registered output port with a one-cycle strobe,
// conditional branch, jump and HALT.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high master reset
//   prog_addr  program ROM address (the PC)
//   instr      ROM data for prog_addr, combinational
//   in_data    input port data, sampled only on the accepting edge
//   in_valid   input data available
//   in_ready   core is waiting in IN and accepts in_data
//   outport    registered output port
//   out_valid  one-cycle strobe, outport was updated on the previous edge
//   halted     core stopped by HALT, only reset restarts it
//
// Optional feature macro: PICOMIPS_MUL_EN (opcode 0A = MUL; otherwise NOP).

module picomips_pipe_cpu #(
  parameter int n     = 8,
  parameter int Psize = 6,
  parameter int Rbits = 3
) (
  input  logic                clk,
  input  logic                reset,
  output logic [Psize-1:0]    prog_addr,
  input  logic [6+5+5+n-1:0]  instr,
  input  logic [n-1:0]        in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [n-1:0]        outport,
  output logic                out_valid,
  output logic                halted
);

  localparam int Isize = 6 + 5 + 5 + n;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_ADDI = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_SUBI = 6'h04;
  localparam logic [5:0] OP_LDI  = 6'h05;
  localparam logic [5:0] OP_IN   = 6'h06;
  localparam logic [5:0] OP_OUT  = 6'h07;
  localparam logic [5:0] OP_BEQ  = 6'h08;
  localparam logic [5:0] OP_JMP  = 6'h09;
  localparam logic [5:0] OP_MUL  = 6'h0A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT_IN,
    S_HALT
  } state_t;

  state_t             state;
  logic [Psize-1:0]   pc;
  logic [Isize-1:0]   ir;
  logic [n-1:0]       rf [2**Rbits];

  logic [5:0]         opcode;
  logic [Rbits-1:0]   rd;
  logic [Rbits-1:0]   rs;
  logic [n-1:0]       imm;
  logic [Psize-1:0]   target;
  logic [n-1:0]       rd_val;
  logic [n-1:0]       rs_val;

  logic               we;
  logic [n-1:0]       wd;
  logic               branch;

  // Only the low Rbits of each register field select a register.
  logic               unused_fields;

  assign opcode = ir[Isize-1 -: 6];
  assign rd     = ir[Isize-12+Rbits -: Rbits];
  assign rs     = ir[Isize-17+Rbits -: Rbits];
  assign imm    = ir[n-1:0];
  assign target = imm[Psize-1:0];

  assign unused_fields = ^{ir[Isize-7 -: 5], ir[Isize-12 -: 5]};

  // R0 is hardwired to zero on read; writes to it are dropped below.
  assign rd_val = (rd == '0) ? '0 : rf[rd];
  assign rs_val = (rs == '0) ? '0 : rf[rs];

  assign prog_addr = pc;

  // Execute-stage decode: register write-back and branch decision.
  always_comb begin
    we     = 1'b0;
    wd     = rd_val;
    branch = 1'b0;
    if (!reset) begin
      if (state == S_RUN) begin
        case (opcode)
          OP_ADD:  begin we = 1'b1; wd = rd_val + rs_val; end
          OP_ADDI: begin we = 1'b1; wd = rd_val + imm;    end
          OP_SUB:  begin we = 1'b1; wd = rd_val - rs_val; end
          OP_SUBI: begin we = 1'b1; wd = rd_val - imm;    end
          OP_LDI:  begin we = 1'b1; wd = imm;             end
`ifdef PICOMIPS_MUL_EN
          OP_MUL:  begin we = 1'b1; wd = rd_val * rs_val; end
`endif
          OP_BEQ:  branch = (rd_val == rs_val);
          OP_JMP:  branch = 1'b1;
          default: ;
        endcase
      end else if (state == S_WAIT_IN && in_valid) begin
        we = 1'b1;
        wd = in_data;
      end
    end
  end

  // Register file is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we && rd != '0) begin
      rf[rd] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      state     <= S_RUN;
      outport   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          out_valid <= 1'b0;
          pc        <= pc + 1'b1;
          ir        <= instr;
          case (opcode)
            OP_OUT: begin
              outport   <= rs_val;
              out_valid <= 1'b1;
            end
            OP_IN: begin
              // Hold the fetch so the instruction after IN is not lost.
              pc       <= pc;
              ir       <= ir;
              in_ready <= 1'b1;
              state    <= S_WAIT_IN;
            end
            OP_HALT: begin
              pc     <= pc;
              ir     <= ir;
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: ;
          endcase
          // Taken branch: the slot fetched alongside it is flushed to NOP.
          if (branch) begin
            pc <= target;
            ir <= OP_NOP << (Isize - 6);
          end
        end
        S_WAIT_IN: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            in_ready <= 1'b0;
            pc       <= pc + 1'b1;
            ir       <= instr;
            state    <= S_RUN;
          end
        end
        S_HALT: begin
          out_valid <= 1'b0;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule
